// File: rtl/xswitch_mon_pkg.sv
// Shared definitions for the xswitch protocol monitor: check indices and saturating arithmetic.
package xswitch_mon_pkg;

  typedef enum logic [1:0] {
    CHK_VALID = 2'd0,
    CHK_DATA  = 2'd1,
    CHK_ADDR  = 2'd2,
    CHK_HS    = 2'd3
  } chk_e;

  localparam int NUM_CHK = 4;

  // Counters up to 32 bits wide share this adder; callers resize to CNT_W.
  function automatic logic [31:0] sat_inc(logic [31:0] value, logic [31:0] inc, logic [31:0] limit);
    logic [32:0] sum;
    sum = {1'b0, value} + {1'b0, inc};
    return (sum > {1'b0, limit}) ? limit : sum[31:0];
  endfunction

endpackage

// File: rtl/xswitch_mon_delay.sv
// Fixed-depth shift register for one output's expected frame; DEPTH=0 is a plain wire.
module xswitch_mon_delay #(
  parameter type item_t = logic,
  parameter int  DEPTH  = 0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  clr,
  input  item_t din,
  output item_t dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, reset, clr};
    assign dout = din;
  end else begin : g_pipe
    item_t stage_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else if (clr) begin
        for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else begin
        stage_q[0] <= din;
        for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/xswitch_protocol_monitor.sv
// Run-time routing and handshake checker for an NUM_PORTS x NUM_PORTS xswitch.
module xswitch_protocol_monitor
  import xswitch_mon_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = $clog2(NUM_PORTS),
  parameter int DATA_W    = 8,
  parameter int LATENCY   = 0,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mon_en,
  input  logic                        clr,
  input  logic [NUM_PORTS-1:0]        valid_in,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_in,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  input  logic [NUM_PORTS-1:0]        rcv_rdy,
  input  logic [NUM_PORTS-1:0]        valid_out,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_out,
  input  logic [NUM_PORTS*DATA_W-1:0] data_out,
  input  logic [NUM_PORTS-1:0]        data_rd,
  output logic [NUM_CHK-1:0]          err_flags,
  output logic [ADDR_W-1:0]           err_port,
  output logic [CNT_W-1:0]            err_cnt,
  output logic [NUM_PORTS*CNT_W-1:0]  pkt_cnt,
  output logic                        irq
);

  typedef struct packed {
    logic                             vld;
    logic [NUM_PORTS-1:0]             req;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data;
  } expect_t;

  localparam int          ADDR_SPAN = 1 << ADDR_W;
  localparam logic [31:0] CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);

  expect_t exp_in [NUM_PORTS];
  expect_t exp_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0][NUM_CHK-1:0] err_now;

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      exp_in[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (mon_en && valid_in[i] && int'(addr_in[i*ADDR_W +: ADDR_W]) == o) begin
          exp_in[o].req[i]  = 1'b1;
          exp_in[o].data[i] = data_in[i*DATA_W +: DATA_W];
        end
      end
      exp_in[o].vld = |exp_in[o].req;
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [ADDR_W-1:0]    src;
    logic [DATA_W-1:0]    dout;
    logic [ADDR_SPAN-1:0] req_ext;
    logic [ADDR_SPAN-1:0] rdy_ext;
    logic                 src_ok;
    logic                 hs_vld_q;
    logic [ADDR_W-1:0]    hs_src_q;
    logic [CNT_W-1:0]     pkt_q;

    xswitch_mon_delay #(.item_t(expect_t), .DEPTH(LATENCY)) u_delay (
      .clk  (clk),
      .reset(reset),
      .clr  (clr),
      .din  (exp_in[o]),
      .dout (exp_d[o])
    );

    // Widened views keep indexing safe when NUM_PORTS is not a power of two.
    assign src     = addr_out[o*ADDR_W +: ADDR_W];
    assign dout    = data_out[o*DATA_W +: DATA_W];
    assign req_ext = ADDR_SPAN'(exp_d[o].req);
    assign rdy_ext = ADDR_SPAN'(rcv_rdy);
    assign src_ok  = req_ext[src];

    assign err_now[o] = {
      mon_en && hs_vld_q && data_rd[o] && !rdy_ext[hs_src_q],
      mon_en && valid_out[o] && !src_ok,
      mon_en && valid_out[o] && src_ok && (dout != exp_d[o].data[src]),
      mon_en && (exp_d[o].vld != valid_out[o])
    };

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hs_vld_q <= 1'b0;
        hs_src_q <= '0;
        pkt_q    <= '0;
      end else if (clr) begin
        hs_vld_q <= 1'b0;
        hs_src_q <= '0;
        pkt_q    <= '0;
      end else begin
        hs_vld_q <= mon_en && valid_out[o];
        hs_src_q <= src;
        if (mon_en && valid_out[o]) pkt_q <= CNT_W'(sat_inc(32'(pkt_q), 32'd1, CNT_MAX));
      end
    end

    assign pkt_cnt[o*CNT_W +: CNT_W] = pkt_q;
  end

  logic [NUM_CHK-1:0] err_or;
  logic [31:0]        err_num;
  logic [ADDR_W-1:0]  err_first;

  // Walk downwards so the lowest failing output is the one left in err_first.
  always_comb begin
    err_or    = '0;
    err_num   = '0;
    err_first = '0;
    for (int o = NUM_PORTS - 1; o >= 0; o--) begin
      err_or  = err_or | err_now[o];
      err_num = err_num + 32'($countones(err_now[o]));
      if (|err_now[o]) err_first = ADDR_W'(o);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flags <= '0;
      err_port  <= '0;
      err_cnt   <= '0;
      irq       <= 1'b0;
    end else if (clr) begin
      err_flags <= '0;
      err_port  <= '0;
      err_cnt   <= '0;
      irq       <= 1'b0;
    end else begin
      err_flags <= err_flags | err_or;
      if (err_flags == '0 && err_or != '0) err_port <= err_first;
      err_cnt <= CNT_W'(sat_inc(32'(err_cnt), err_num, CNT_MAX));
      irq     <= |err_flags;
    end
  end

endmodule

// File: tb/tb_xswitch_protocol_monitor.sv
// Bench for xswitch_protocol_monitor: directed scenarios plus randomized traffic against a set-based model.
module tb_xswitch_protocol_monitor;

  localparam int NP   = 4;
  localparam int AW   = 2;
  localparam int DW   = 8;
  localparam int LAT  = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset, mon_en, clr;
  logic [NP-1:0]   valid_in, rcv_rdy, valid_out, data_rd;
  logic [NP*AW-1:0] addr_in, addr_out;
  logic [NP*DW-1:0] data_in, data_out;
  logic [3:0]      err_flags;
  logic [AW-1:0]   err_port;
  logic [CW-1:0]   err_cnt;
  logic [NP*CW-1:0] pkt_cnt;
  logic            irq;

  always #5 clk = ~clk;

  xswitch_protocol_monitor #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .mon_en(mon_en), .clr(clr),
    .valid_in(valid_in), .addr_in(addr_in), .data_in(data_in), .rcv_rdy(rcv_rdy),
    .valid_out(valid_out), .addr_out(addr_out), .data_out(data_out), .data_rd(data_rd),
    .err_flags(err_flags), .err_port(err_port), .err_cnt(err_cnt), .pkt_cnt(pkt_cnt), .irq(irq)
  );

  typedef struct packed {
    bit                   ok;
    bit [NP-1:0]          vin;
    bit [NP-1:0][AW-1:0]  ain;
    bit [NP-1:0][DW-1:0]  din;
  } snap_t;

  int n_tests = 0;
  int n_fail  = 0;

  bit [3:0]  m_flags;
  bit [AW-1:0] m_port;
  int        m_cnt;
  int        m_pkt [NP];
  bit        m_irq;
  bit        pend [NP];
  bit [AW-1:0] psrc [NP];
  snap_t     hist [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit [NP-1:0] req_set(snap_t s, int o);
    bit [NP-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++)
      if (s.ok && s.vin[i] && int'(s.ain[i]) == o) r[i] = 1'b1;
    return r;
  endfunction

  function automatic snap_t cur_snap();
    snap_t s;
    s.ok  = mon_en;
    s.vin = valid_in;
    s.ain = addr_in;
    s.din = data_in;
    return s;
  endfunction

  function automatic snap_t exp_snap(snap_t c);
    snap_t s;
    if (LAT == 0) s = c;
    else s = hist[0];
    return s;
  endfunction

  task automatic model_clear();
    m_flags = '0; m_port = '0; m_cnt = 0; m_irq = 1'b0;
    for (int o = 0; o < NP; o++) begin
      m_pkt[o] = 0; pend[o] = 1'b0; psrc[o] = '0;
    end
    hist.delete();
    for (int k = 0; k < LAT; k++) hist.push_back('0);
  endtask

  task automatic idle();
    valid_in = '0; addr_in = '0; data_in = '0; rcv_rdy = '1;
    valid_out = '0; addr_out = '0; data_out = '0; data_rd = '0;
    mon_en = 1'b1; clr = 1'b0;
  endtask

  task automatic set_in(input int i, input int a, input int d);
    valid_in[i] = 1'b1;
    addr_in[i*AW +: AW] = AW'(a);
    data_in[i*DW +: DW] = DW'(d);
  endtask

  task automatic set_out(input int o, input int a, input int d);
    valid_out[o] = 1'b1;
    addr_out[o*AW +: AW] = AW'(a);
    data_out[o*DW +: DW] = DW'(d);
  endtask

  // One clock: compare registered outputs, then advance the model with this cycle's inputs.
  task automatic step();
    snap_t c, e;
    bit [NP-1:0] r;
    bit [3:0] eo, or_b;
    int nerr, first, src;
    @(negedge clk);
    check_val("err_flags", 64'(err_flags), 64'(m_flags));
    check_val("err_port", 64'(err_port), 64'(m_port));
    check_val("err_cnt", 64'(err_cnt), 64'(m_cnt));
    check_val("irq", 64'(irq), 64'(m_irq));
    for (int o = 0; o < NP; o++) check_val("pkt_cnt", 64'(pkt_cnt[o*CW +: CW]), 64'(m_pkt[o]));
    c = cur_snap();
    e = exp_snap(c);
    nerr = 0; or_b = '0; first = -1;
    for (int o = 0; o < NP; o++) begin
      eo = '0;
      if (mon_en) begin
        r = req_set(e, o);
        src = int'(addr_out[o*AW +: AW]);
        if ((r != 0) != valid_out[o]) eo[0] = 1'b1;
        if (valid_out[o]) begin
          if (src >= NP || !r[src]) eo[2] = 1'b1;
          else if (data_out[o*DW +: DW] != e.din[src]) eo[1] = 1'b1;
        end
        if (pend[o] && data_rd[o] && !rcv_rdy[psrc[o]]) eo[3] = 1'b1;
      end
      or_b |= eo;
      nerr += $countones(eo);
      if (eo != 0 && first < 0) first = o;
    end
    if (clr) model_clear();
    else begin
      if (m_flags == 0 && or_b != 0) m_port = AW'(first);
      m_irq = (m_flags != 0);
      m_flags |= or_b;
      m_cnt = (m_cnt + nerr > CMAX) ? CMAX : m_cnt + nerr;
      for (int o = 0; o < NP; o++) begin
        if (mon_en && valid_out[o] && m_pkt[o] < CMAX) m_pkt[o]++;
        pend[o] = mon_en && valid_out[o];
        psrc[o] = addr_out[o*AW +: AW];
      end
      if (LAT > 0) begin
        void'(hist.pop_front());
        hist.push_back(c);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    check_val("rst_flags", 64'(err_flags), 64'd0);
    check_val("rst_cnt", 64'(err_cnt), 64'd0);
    check_val("rst_pkt", 64'(pkt_cnt), 64'd0);
    check_val("rst_irq", 64'(irq), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive_rand();
    snap_t c, e;
    bit [NP-1:0] r;
    int m;
    mon_en = ($urandom_range(0, 9) != 0);
    clr    = ($urandom_range(0, 59) == 0);
    for (int i = 0; i < NP; i++) begin
      valid_in[i] = 1'($urandom_range(0, 1));
      addr_in[i*AW +: AW] = AW'($urandom_range(0, NP - 1));
      data_in[i*DW +: DW] = DW'($urandom);
    end
    c = cur_snap();
    e = exp_snap(c);
    rcv_rdy = NP'($urandom);
    for (int o = 0; o < NP; o++) begin
      r = req_set(e, o);
      valid_out[o] = (r != 0);
      addr_out[o*AW +: AW] = AW'($urandom_range(0, NP - 1));
      data_out[o*DW +: DW] = DW'($urandom);
      if (r != 0) begin
        do m = $urandom_range(0, NP - 1); while (!r[m]);
        addr_out[o*AW +: AW] = AW'(m);
        data_out[o*DW +: DW] = e.din[m];
      end
      if ($urandom_range(0, 99) < 4) begin
        case ($urandom_range(0, 2))
          0: valid_out[o] = ~valid_out[o];
          1: addr_out[o*AW +: AW] = addr_out[o*AW +: AW] ^ AW'(1);
          default: data_out[o*DW +: DW] = data_out[o*DW +: DW] ^ DW'(8'h10);
        endcase
      end
      data_rd[o] = 1'($urandom_range(0, 1));
      if (pend[o] && !rcv_rdy[psrc[o]] && $urandom_range(0, 9) != 0) data_rd[o] = 1'b0;
    end
  endtask

  initial begin
    idle();
    model_clear();
    do_reset();

    // T1: single packet in0 -> out2, reported correctly after LAT cycles
    idle(); set_in(0, 2, 8'hA5); step();
    idle(); step();
    idle(); set_out(2, 0, 8'hA5); step();
    check_val("t1_flags", 64'(err_flags), 64'd0);
    check_val("t1_pkt2", 64'(pkt_cnt[2*CW +: CW]), 64'd1);

    // T2: corrupted payload on out3
    idle(); clr = 1'b1; step();
    idle(); set_in(1, 3, 8'h3C); step();
    idle(); step();
    idle(); set_out(3, 1, 8'h3D); step();
    check_val("t2_flags", 64'(err_flags), 64'h2);
    check_val("t2_port", 64'(err_port), 64'd3);
    check_val("t2_cnt", 64'(err_cnt), 64'd1);
    check_val("t2_irq_lag", 64'(irq), 64'd0);
    idle(); step();
    check_val("t2_irq", 64'(irq), 64'd1);

    // T3: contention on out1; either source is legal, a non-member is not
    idle(); clr = 1'b1; step();
    idle(); set_in(0, 1, 8'h11); set_in(3, 1, 8'h33); step();
    idle(); step();
    idle(); set_out(1, 3, 8'h33); step();
    check_val("t3_legal", 64'(err_flags), 64'd0);
    idle(); set_in(0, 1, 8'h11); set_in(3, 1, 8'h33); step();
    idle(); step();
    idle(); set_out(1, 2, 8'h33); step();
    check_val("t3_addr", 64'(err_flags), 64'h4);
    check_val("t3_port", 64'(err_port), 64'd1);

    // T4: read strobe while the source is not ready
    idle(); clr = 1'b1; step();
    idle(); set_in(2, 0, 8'h55); step();
    idle(); step();
    idle(); set_out(0, 2, 8'h55); step();
    idle(); rcv_rdy = 4'b1011; data_rd[0] = 1'b1; step();
    check_val("t4_hs", 64'(err_flags), 64'h8);

    // T5: 20 packets saturate the 4-bit counter, clr empties everything
    idle(); clr = 1'b1; step();
    for (int k = 0; k < 22; k++) begin
      idle();
      if (k < 20) set_in(0, 0, k);
      if (k >= 2) set_out(0, 0, k - 2);
      step();
    end
    check_val("t5_sat", 64'(pkt_cnt[0 +: CW]), 64'd15);
    check_val("t5_flags", 64'(err_flags), 64'd0);
    idle(); clr = 1'b1; step();
    check_val("t5_clr_pkt", 64'(pkt_cnt), 64'd0);
    check_val("t5_clr_cnt", 64'(err_cnt), 64'd0);

    // T6: reset mid-flight drops the expectation; mon_en=0 ignores stray valid_out
    idle(); clr = 1'b1; step();
    idle(); set_in(1, 2, 8'h77); step();
    idle(); do_reset();
    for (int k = 0; k < LAT + 1; k++) begin idle(); step(); end
    check_val("t6_rst", 64'(err_flags), 64'd0);
    idle(); mon_en = 1'b0; set_out(3, 1, 8'h12); step();
    idle(); step();
    check_val("t6_off_flags", 64'(err_flags), 64'd0);
    check_val("t6_off_pkt", 64'(pkt_cnt[3*CW +: CW]), 64'd0);

    // Randomized traffic with sparse fault injection
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        idle(); do_reset();
      end
      drive_rand();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
